// File: rtl/sdram_read_buffer.sv
// Read-side buffer behind the SDRAM controller: captures burst words into a FIFO
// and throttles the controller with pause/unpause pulses based on fill level.
module sdram_read_buffer #(
  parameter int DEPTH     = 64,
  parameter int HIGH_MARK = 56,
  parameter int LOW_MARK  = 16
) (
  input  logic                     ck143,
  input  logic                     reset_n_reg,
  input  logic [15:0]              in_dq,
  input  logic                     in_valid,
  output logic                     pause,
  output logic                     unpause,
  input  logic                     rd_en,
  output logic [15:0]              rd_data,
  output logic                     rd_valid,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {RUN, HOLD} throttle_t;

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          pop_ok;
  logic          push_ok;
  logic [CW-1:0] count_next;
  throttle_t     state;
  throttle_t     state_next;
  logic          pause_next;
  logic          unpause_next;

  // A pop frees a slot in the same cycle, so a push at full is accepted when paired with a pop.
  always_comb begin
    pop_ok     = rd_en && !empty;
    push_ok    = in_valid && (!full || pop_ok);
    count_next = count;
    if (push_ok && !pop_ok)
      count_next = count + CW'(1);
    else if (pop_ok && !push_ok)
      count_next = count - CW'(1);
  end

  always_ff @(posedge ck143) begin
    if (push_ok)
      mem[wr_ptr] <= in_dq;
  end

  always_ff @(posedge ck143 or negedge reset_n_reg) begin
    if (!reset_n_reg) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      empty    <= 1'b1;
      full     <= 1'b0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok) begin
        rd_ptr  <= rd_ptr + AW'(1);
        rd_data <= mem[rd_ptr];
      end
      rd_valid <= pop_ok;
      count    <= count_next;
      empty    <= (count_next == '0);
      full     <= (count_next == CW'(DEPTH));
      if (in_valid && !push_ok)
        overflow <= 1'b1;
    end
  end

  // Throttle decisions look at the post-update occupancy so pulses line up with count.
  always_comb begin
    state_next   = state;
    pause_next   = 1'b0;
    unpause_next = 1'b0;
    case (state)
      RUN: begin
        if (count_next >= CW'(HIGH_MARK)) begin
          pause_next = 1'b1;
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (count_next <= CW'(LOW_MARK)) begin
          unpause_next = 1'b1;
          state_next   = RUN;
        end
      end
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge ck143 or negedge reset_n_reg) begin
    if (!reset_n_reg) begin
      state   <= RUN;
      pause   <= 1'b0;
      unpause <= 1'b0;
    end else begin
      state   <= state_next;
      pause   <= pause_next;
      unpause <= unpause_next;
    end
  end

endmodule

// File: tb/tb_sdram_read_buffer.sv
// Bench for sdram_read_buffer: scenario tasks checked against a queue-based
// occupancy/throttle model of the buffer.
module tb_sdram_read_buffer;

  localparam int DEPTH = 64;
  localparam int HIGH  = 56;
  localparam int LOW   = 16;

  logic        ck143;
  logic        reset_n_reg;
  logic [15:0] in_dq;
  logic        in_valid;
  logic        pause;
  logic        unpause;
  logic        rd_en;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        empty;
  logic        full;
  logic [6:0]  count;
  logic        overflow;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] q[$];
  logic        m_overflow;
  logic        m_paused;
  logic        m_pause;
  logic        m_unpause;
  logic        m_rd_valid;
  logic [15:0] m_rd_data;

  sdram_read_buffer #(.DEPTH(DEPTH), .HIGH_MARK(HIGH), .LOW_MARK(LOW)) dut (
    .ck143(ck143), .reset_n_reg(reset_n_reg), .in_dq(in_dq), .in_valid(in_valid),
    .pause(pause), .unpause(unpause), .rd_en(rd_en), .rd_data(rd_data),
    .rd_valid(rd_valid), .empty(empty), .full(full), .count(count), .overflow(overflow)
  );

  initial ck143 = 1'b0;
  always #5 ck143 = ~ck143;

  task automatic model_reset();
    q.delete();
    m_overflow = 0; m_paused = 0; m_pause = 0; m_unpause = 0;
    m_rd_valid = 0; m_rd_data = '0;
  endtask

  // Advance the model by one clock using the current inputs, then let the DUT clock once.
  task automatic cycle();
    bit pop, push;
    int n;
    pop  = rd_en && (q.size() > 0);
    push = in_valid && ((q.size() < DEPTH) || pop);
    m_rd_valid = pop;
    if (pop) m_rd_data = q.pop_front();
    if (push) q.push_back(in_dq);
    else if (in_valid) m_overflow = 1;
    n = q.size();
    m_pause = 0; m_unpause = 0;
    if (!m_paused && n >= HIGH) begin m_pause = 1; m_paused = 1; end
    else if (m_paused && n <= LOW) begin m_unpause = 1; m_paused = 0; end
    @(posedge ck143);
    #1;
  endtask

  task automatic apply_reset();
    reset_n_reg = 0; in_valid = 0; rd_en = 0; in_dq = '0;
    model_reset();
    repeat (2) @(posedge ck143);
    #1;
    reset_n_reg = 1;
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++;
    if ({empty, full, pause, unpause, rd_valid, overflow} !== 6'b100000 || count !== 7'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_initial: got e/f/p/u/v/o=%b count=%0d expected 100000 count=0",
               {empty, full, pause, unpause, rd_valid, overflow}, count);
    end
    in_valid = 1; rd_en = 0;
    for (int i = 0; i < 5; i++) begin
      in_dq = 16'($urandom);
      cycle();
    end
    n_checks++;
    if (count !== 7'(q.size())) begin
      n_fail++;
      $display("[TB] FAIL reset_pretraffic_count: got %0d expected %0d", count, q.size());
    end
    rd_en = 1;
    #3;
    reset_n_reg = 0;
    #1;
    model_reset();
    n_checks++;
    if ({empty, full, pause, unpause, rd_valid, overflow} !== 6'b100000 || count !== 7'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_async: got e/f/p/u/v/o=%b count=%0d expected 100000 count=0",
               {empty, full, pause, unpause, rd_valid, overflow}, count);
    end
    repeat (2) @(posedge ck143);
    #1;
    in_valid = 0;
    reset_n_reg = 1;
    for (int i = 0; i < 3; i++) begin
      rd_en = 1'($urandom);
      cycle();
      n_checks++;
      if ({empty, full, pause, unpause, rd_valid, overflow} !== 6'b100000 || count !== 7'd0
          || rd_data !== 16'h0000) begin
        n_fail++;
        $display("[TB] FAIL reset_hold: got e/f/p/u/v/o=%b count=%0d data=%h expected 100000 0 0000",
                 {empty, full, pause, unpause, rd_valid, overflow}, count, rd_data);
      end
    end
  endtask

  task automatic test_order();
    apply_reset();
    in_valid = 1; rd_en = 0;
    for (int i = 1; i <= 32; i++) begin
      in_dq = 16'(i);
      cycle();
      n_checks++;
      if (count !== 7'(i) || empty !== 1'b0 || pause !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL order_fill: got count=%0d empty=%b pause=%b expected %0d 0 0",
                 count, empty, pause, i);
      end
    end
    in_valid = 0; rd_en = 1;
    for (int i = 1; i <= 32; i++) begin
      cycle();
      n_checks++;
      if (rd_valid !== 1'b1 || rd_data !== 16'(i) || count !== 7'(32 - i)) begin
        n_fail++;
        $display("[TB] FAIL order_pop: got valid=%b data=%h count=%0d expected 1 %h %0d",
                 rd_valid, rd_data, count, 16'(i), 32 - i);
      end
    end
    n_checks++;
    if (empty !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL order_empty: got %b expected 1", empty);
    end
    rd_en = 0;
    cycle();
    n_checks++;
    if (rd_valid !== 1'b0 || rd_data !== 16'h0020) begin
      n_fail++;
      $display("[TB] FAIL order_idle: got valid=%b data=%h expected 0 0020", rd_valid, rd_data);
    end
  endtask

  task automatic test_throttle();
    int pauses = 0;
    int unpauses = 0;
    apply_reset();
    in_valid = 1; rd_en = 0;
    for (int i = 0; i < 60; i++) begin
      in_dq = 16'($urandom);
      cycle();
      n_checks++;
      if (pause !== m_pause || unpause !== m_unpause) begin
        n_fail++;
        $display("[TB] FAIL throttle_fill: got p/u=%b%b expected %b%b at count %0d",
                 pause, unpause, m_pause, m_unpause, q.size());
      end
      if (pause === 1'b1) begin
        pauses++;
        n_checks++;
        if (count !== 7'(HIGH)) begin
          n_fail++;
          $display("[TB] FAIL throttle_pause_level: got count=%0d expected %0d", count, HIGH);
        end
      end
    end
    in_valid = 0; rd_en = 1;
    for (int i = 0; i < 50; i++) begin
      cycle();
      n_checks++;
      if (pause !== m_pause || unpause !== m_unpause || rd_data !== m_rd_data) begin
        n_fail++;
        $display("[TB] FAIL throttle_drain: got p/u=%b%b data=%h expected %b%b %h",
                 pause, unpause, rd_data, m_pause, m_unpause, m_rd_data);
      end
      if (pause === 1'b1) pauses++;
      if (unpause === 1'b1) begin
        unpauses++;
        n_checks++;
        if (count !== 7'(LOW)) begin
          n_fail++;
          $display("[TB] FAIL throttle_unpause_level: got count=%0d expected %0d", count, LOW);
        end
      end
    end
    n_checks++;
    if (pauses != 1 || unpauses != 1) begin
      n_fail++;
      $display("[TB] FAIL throttle_pulse_count: got pause=%0d unpause=%0d expected 1 1",
               pauses, unpauses);
    end
  endtask

  task automatic test_full();
    apply_reset();
    in_valid = 1; rd_en = 0;
    for (int i = 0; i < DEPTH; i++) begin
      in_dq = 16'h1000 + 16'(i);
      cycle();
    end
    n_checks++;
    if (full !== 1'b1 || count !== 7'd64 || overflow !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL full_flag: got full=%b count=%0d ovf=%b expected 1 64 0",
               full, count, overflow);
    end
    in_dq = 16'hDEAD;
    cycle();
    n_checks++;
    if (overflow !== 1'b1 || count !== 7'd64 || full !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL full_drop: got ovf=%b count=%0d full=%b expected 1 64 1",
               overflow, count, full);
    end
    in_dq = 16'hBEEF; rd_en = 1;
    cycle();
    n_checks++;
    if (count !== 7'd64 || full !== 1'b1 || rd_valid !== 1'b1 || rd_data !== 16'h1000) begin
      n_fail++;
      $display("[TB] FAIL full_pushpop: got count=%0d full=%b valid=%b data=%h expected 64 1 1 1000",
               count, full, rd_valid, rd_data);
    end
    in_valid = 0;
    for (int i = 0; i < DEPTH; i++) begin
      cycle();
      n_checks++;
      if (rd_data !== m_rd_data || count !== 7'(q.size()) || unpause !== m_unpause) begin
        n_fail++;
        $display("[TB] FAIL full_drain: got data=%h count=%0d unp=%b expected %h %0d %b",
                 rd_data, count, unpause, m_rd_data, q.size(), m_unpause);
      end
    end
    n_checks++;
    if (empty !== 1'b1 || overflow !== 1'b1 || rd_data !== 16'hBEEF) begin
      n_fail++;
      $display("[TB] FAIL full_sticky: got empty=%b ovf=%b last=%h expected 1 1 beef",
               empty, overflow, rd_data);
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    for (int i = 0; i < 200; i++) begin
      if (i < 100) begin
        in_valid = ($urandom_range(0, 3) != 0);
        rd_en    = ($urandom_range(0, 3) == 0);
      end else begin
        in_valid = ($urandom_range(0, 3) == 0);
        rd_en    = ($urandom_range(0, 3) != 0);
      end
      in_dq = 16'($urandom);
      cycle();
      n_checks++;
      if (count !== 7'(q.size()) || empty !== (q.size() == 0) || full !== (q.size() == DEPTH)
          || rd_valid !== m_rd_valid || rd_data !== m_rd_data || pause !== m_pause
          || unpause !== m_unpause || overflow !== m_overflow) begin
        n_fail++;
        $display("[TB] FAIL wrap_cycle%0d: got cnt=%0d e=%b f=%b v=%b d=%h p=%b u=%b o=%b expected cnt=%0d e=%b f=%b v=%b d=%h p=%b u=%b o=%b",
                 i, count, empty, full, rd_valid, rd_data, pause, unpause, overflow,
                 q.size(), q.size() == 0, q.size() == DEPTH, m_rd_valid, m_rd_data,
                 m_pause, m_unpause, m_overflow);
      end
    end
  endtask

  task automatic test_empty_pop();
    apply_reset();
    in_valid = 0; rd_en = 1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_checks++;
      if (rd_valid !== 1'b0 || count !== 7'd0 || empty !== 1'b1 || rd_data !== 16'h0000) begin
        n_fail++;
        $display("[TB] FAIL empty_pop: got valid=%b count=%0d empty=%b data=%h expected 0 0 1 0000",
                 rd_valid, count, empty, rd_data);
      end
    end
    in_valid = 1; in_dq = 16'h5A5A;
    cycle();
    n_checks++;
    if (rd_valid !== 1'b0 || count !== 7'd1 || empty !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL empty_push_no_bypass: got valid=%b count=%0d empty=%b expected 0 1 0",
               rd_valid, count, empty);
    end
    in_valid = 0;
    cycle();
    n_checks++;
    if (rd_valid !== 1'b1 || rd_data !== 16'h5A5A || count !== 7'd0 || empty !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL empty_ptr_hold: got valid=%b data=%h count=%0d empty=%b expected 1 5a5a 0 1",
               rd_valid, rd_data, count, empty);
    end
  endtask

  initial begin
    reset_n_reg = 0; in_valid = 0; rd_en = 0; in_dq = '0;
    model_reset();
    test_reset();
    test_order();
    test_throttle();
    test_full();
    test_wrap();
    test_empty_pop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
